// File: rtl/stopwatch_core.sv
// Keypad-driven stopwatch: run/stop/clear control, tick prescaler and a cascaded N-digit BCD counter.
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 10,
   parameter int unsigned NDIGITS = 4,
   parameter int          WRAP    = 1,
   parameter logic [3:0]  KEY_CLR = 4'd10,
   parameter logic [3:0]  KEY_LAP = 4'd11,
   parameter logic [3:0]  KEY_RUN = 4'd12,
   parameter logic [3:0]  KEY_STOP = 4'd13
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             key_code,
   input  logic                   key_vld,
   output logic [4*NDIGITS-1:0]   digits,
   output logic                   running,
   output logic                   lap_active,
   output logic                   ovf
);

   localparam int unsigned W    = 4 * NDIGITS;
   localparam int unsigned DIV  = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
   localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] TERM = PW'(DIV - 1);

`ifdef STOPWATCH_LAP_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

   state_t          state;
   logic [W-1:0]    count;
   logic [W-1:0]    count_inc;
   logic [PW-1:0]   presc;
   logic            live;
   logic            tick;
   logic            carry;
   logic            all_nines;
   logic            sat_hit;
   logic            key_clr;
   logic            key_lap;
   logic            key_run;
   logic            key_stop;
`ifdef STOPWATCH_LAP_EN
   logic [W-1:0]    lap_reg;
`endif

   assign key_clr  = key_vld && (key_code == KEY_CLR);
   assign key_lap  = key_vld && (key_code == KEY_LAP);
   assign key_run  = key_vld && (key_code == KEY_RUN);
   assign key_stop = key_vld && (key_code == KEY_STOP);

`ifdef STOPWATCH_LAP_EN
   assign live = (state == S_RUN) || (state == S_LAP);
`else
   assign live = (state == S_RUN);
`endif
   assign tick    = live && (presc == TERM);
   assign sat_hit = tick && all_nines && (WRAP == 0);

   // Ripple BCD increment: digit k steps only when every lower digit is 9.
   always_comb begin
      count_inc = count;
      carry     = 1'b1;
      for (int k = 0; k < NDIGITS; k++) begin
         if (carry) begin
            count_inc[4*k +: 4] = (count[4*k +: 4] == 4'd9) ? 4'd0 : count[4*k +: 4] + 4'd1;
         end
         carry = carry && (count[4*k +: 4] == 4'd9);
      end
      all_nines = carry;
   end

   // rst_n release is expected to arrive already synchronised to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         count   <= '0;
         presc   <= '0;
         ovf     <= 1'b0;
         digits  <= '0;
         running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_reg    <= '0;
         lap_active <= 1'b0;
`endif
      end else begin
         if (live) begin
            presc <= tick ? '0 : presc + PW'(1);
         end

         if (tick) begin
            count <= count_inc;
            if (all_nines) begin
               ovf   <= 1'b1;
               count <= (WRAP != 0) ? count_inc : count;
            end
         end

`ifdef STOPWATCH_LAP_EN
         digits <= (state == S_LAP) ? lap_reg : count;
`else
         digits <= count;
`endif

         case (state)
            S_IDLE: begin
               if (key_run) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
            S_RUN: begin
               if (key_stop) begin
                  state   <= S_PAUSE;
                  running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
               end else if (key_lap) begin
                  lap_reg    <= count;
                  state      <= S_LAP;
                  lap_active <= 1'b1;
`else
               end else if (key_lap) begin
                  // Lap capture is not built: the key leaves the stopwatch running.
                  state <= S_RUN;
`endif
               end
            end
            S_PAUSE: begin
               if (key_run) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
`ifdef STOPWATCH_LAP_EN
            S_LAP: begin
               if (key_lap) begin
                  lap_reg <= count;
               end else if (key_run) begin
                  state      <= S_RUN;
                  lap_active <= 1'b0;
               end else if (key_stop) begin
                  state      <= S_PAUSE;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end
            end
`endif
            default: begin
               state   <= S_IDLE;
               running <= 1'b0;
            end
         endcase

         // Saturation stops the clock even if a key arrived on the same edge.
         if (sat_hit) begin
            state   <= S_PAUSE;
            running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active <= 1'b0;
`endif
         end

         // Clear overrides everything, including a tick on the same edge.
         if (key_clr) begin
            state   <= S_IDLE;
            count   <= '0;
            presc   <= '0;
            ovf     <= 1'b0;
            running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active <= 1'b0;
`endif
         end
      end
   end

`ifndef STOPWATCH_LAP_EN
   assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with CLK_HZ=20, TICK_HZ=10 (tick every 2 clk), NDIGITS=2.
// Two instances share stimulus: one wrapping (WRAP=1) and one saturating (WRAP=0).
module tb_stopwatch_core;

   localparam logic [3:0] K_CLR  = 4'd10;
   localparam logic [3:0] K_LAP  = 4'd11;
   localparam logic [3:0] K_RUN  = 4'd12;
   localparam logic [3:0] K_STOP = 4'd13;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_code;
   logic       key_vld;

   logic [7:0] digits_w;
   logic       running_w;
   logic       lap_active_w;
   logic       ovf_w;
   logic [7:0] digits_s;
   logic       running_s;
   logic       lap_active_s;
   logic       ovf_s;

   int tests_run;
   int tests_failed;

   stopwatch_core #(
      .CLK_HZ(20), .TICK_HZ(10), .NDIGITS(2), .WRAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_vld(key_vld),
      .digits(digits_w), .running(running_w), .lap_active(lap_active_w), .ovf(ovf_w)
   );

   stopwatch_core #(
      .CLK_HZ(20), .TICK_HZ(10), .NDIGITS(2), .WRAP(0)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_vld(key_vld),
      .digits(digits_s), .running(running_s), .lap_active(lap_active_s), .ovf(ovf_s)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench on a falling edge with reset released.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      key_vld  = 1'b0;
      key_code = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Called on a falling edge; key is sampled on the next rising edge; returns on the following falling edge.
   task automatic press(input logic [3:0] code);
      key_code = code;
      key_vld  = 1'b1;
      @(negedge clk);
      key_vld  = 1'b0;
      key_code = 4'd0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h00 || running_w !== 1'b0 || lap_active_w !== 1'b0 || ovf_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_held: digits=%h run=%b lap=%b ovf=%b, want 00 0 0 0", digits_w, running_w, lap_active_w, ovf_w);
      end
      do_reset();
      tests_run++;
      if (digits_s !== 8'h00 || running_s !== 1'b0 || ovf_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_released_sat: digits=%h run=%b ovf=%b, want 00 0 0", digits_s, running_s, ovf_s);
      end
   endtask

   task automatic test_run_count();
      do_reset();
      press(K_RUN);
      repeat (41) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h20) begin
         tests_failed++;
         $display("FAIL run_count digits: got %h want 20", digits_w);
      end
      tests_run++;
      if (running_w !== 1'b1 || ovf_w !== 1'b0 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL run_count flags: run=%b ovf=%b lap=%b want 1 0 0", running_w, ovf_w, lap_active_w);
      end
   endtask

   task automatic test_stop_resume();
      do_reset();
      press(K_RUN);
      repeat (14) @(negedge clk);
      press(K_STOP);
      tests_run++;
      if (digits_w !== 8'h07 || running_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_at_07: digits=%h run=%b want 07 0", digits_w, running_w);
      end
      repeat (50) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h07 || running_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_hold: digits=%h run=%b want 07 0", digits_w, running_w);
      end
      press(K_STOP);
      press(K_LAP);
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h07 || running_w !== 1'b0 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_ignore_keys: digits=%h run=%b lap=%b want 07 0 0", digits_w, running_w, lap_active_w);
      end
      press(K_RUN);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h07 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL resume_first_cycle: digits=%h run=%b want 07 1", digits_w, running_w);
      end
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h08) begin
         tests_failed++;
         $display("FAIL resume_keeps_fraction: digits=%h want 08", digits_w);
      end
   endtask

   task automatic test_wrap_and_clear();
      do_reset();
      press(K_RUN);
      repeat (199) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h99 || digits_s !== 8'h99 || ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL at_99: wrap=%h/%b sat=%h/%b want 99/0 99/0", digits_w, ovf_w, digits_s, ovf_s);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h00 || ovf_w !== 1'b1 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_rollover: digits=%h ovf=%b run=%b want 00 1 1", digits_w, ovf_w, running_w);
      end
      tests_run++;
      if (digits_s !== 8'h99 || ovf_s !== 1'b1 || running_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL saturate: digits=%h ovf=%b run=%b want 99 1 0", digits_s, ovf_s, running_s);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h01 || ovf_w !== 1'b1 || digits_s !== 8'h99) begin
         tests_failed++;
         $display("FAIL after_wrap: wrap=%h ovf=%b sat=%h want 01 1 99", digits_w, ovf_w, digits_s);
      end
      // this press lands on a tick edge of the wrapping instance
      press(K_CLR);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h00 || running_w !== 1'b0 || ovf_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_on_tick: digits=%h run=%b ovf=%b want 00 0 0", digits_w, running_w, ovf_w);
      end
      tests_run++;
      if (digits_s !== 8'h00 || running_s !== 1'b0 || ovf_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_from_pause: digits=%h run=%b ovf=%b want 00 0 0", digits_s, running_s, ovf_s);
      end
      press(4'd5);
      press(K_STOP);
      repeat (4) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h00 || running_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_ignore_keys: digits=%h run=%b want 00 0", digits_w, running_w);
      end
   endtask

   task automatic test_unknown_keys();
      do_reset();
      press(K_RUN);
      repeat (10) @(negedge clk);
      press(4'd5);
      press(4'd14);
      press(4'd15);
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h07 || running_w !== 1'b1 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL run_unknown_keys: digits=%h run=%b lap=%b want 07 1 0", digits_w, running_w, lap_active_w);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      do_reset();
      press(K_RUN);
      repeat (24) @(negedge clk);
      press(K_LAP);
      repeat (38) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h12 || lap_active_w !== 1'b1 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL lap_frozen: digits=%h lap=%b run=%b want 12 1 1", digits_w, lap_active_w, running_w);
      end
      press(K_RUN);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h32 || lap_active_w !== 1'b0 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL lap_release: digits=%h lap=%b run=%b want 32 0 1", digits_w, lap_active_w, running_w);
      end
      // capture on a tick edge must take the pre-increment count
      press(K_LAP);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h32 || lap_active_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL lap_on_tick: digits=%h lap=%b want 32 1", digits_w, lap_active_w);
      end
      press(K_STOP);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h34 || running_w !== 1'b0 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL lap_stop: digits=%h run=%b lap=%b want 34 0 0", digits_w, running_w, lap_active_w);
      end
      press(K_LAP);
      @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h34 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_lap_ignored: digits=%h lap=%b want 34 0", digits_w, lap_active_w);
      end
   endtask
`else
   task automatic test_lap();
      do_reset();
      press(K_RUN);
      repeat (24) @(negedge clk);
      press(K_LAP);
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h13 || lap_active_w !== 1'b0 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL lap_key_ignored: digits=%h lap=%b run=%b want 13 0 1", digits_w, lap_active_w, running_w);
      end
   endtask
`endif

   task automatic test_async_reset();
      do_reset();
      press(K_RUN);
      repeat (91) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h45 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL before_async_reset: digits=%h run=%b want 45 1", digits_w, running_w);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (digits_w !== 8'h00 || running_w !== 1'b0 || ovf_w !== 1'b0 || lap_active_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: digits=%h run=%b ovf=%b lap=%b want 00 0 0 0", digits_w, running_w, ovf_w, lap_active_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h00 || running_w !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_async_reset: digits=%h run=%b want 00 0", digits_w, running_w);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      press(K_STOP);
      press(K_RUN);
      press(K_STOP);
      tests_run++;
      if (running_w !== 1'b0 || digits_w !== 8'h00) begin
         tests_failed++;
         $display("FAIL b2b_stop: digits=%h run=%b want 00 0", digits_w, running_w);
      end
      press(K_RUN);
      repeat (2) @(negedge clk);
      tests_run++;
      if (digits_w !== 8'h01 || running_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_resume: digits=%h run=%b want 01 1", digits_w, running_w);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      key_vld      = 1'b0;
      key_code     = 4'd0;
      test_reset();
      test_run_count();
      test_stop_resume();
      test_wrap_and_clear();
      test_unknown_keys();
      test_lap();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
